// File: rtl/sub1b.sv
// 1-bit full subtractor slice: combinational difference/borrow/propagate plus
// a one-cycle registered copy with synchronous active-high reset.
module sub1b (
  input  logic iA,
  input  logic iB,
  input  logic iC,
  output logic oS,
  output logic oC,
  output logic oP,
  input  logic iCLK,
  input  logic iRST,
  output logic qS,
  output logic qC,
  output logic qP
);

  logic borrow_gen;
  logic borrow_prop;

  logic s_d, c_d, p_d;
  logic s_q, c_q, p_q;

  // A borrow is generated when 0-1, and passed through when the operand bits match.
  always_comb begin
    borrow_gen  = ~iA & iB;
    borrow_prop = ~(iA ^ iB);
    oS          = iA ^ iB ^ iC;
    oC          = borrow_gen | (borrow_prop & iC);
    oP          = borrow_prop;
  end

  always_comb begin
    s_d = oS;
    c_d = oC;
    p_d = oP;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end

  assign qS = s_q;
  assign qC = c_q;
  assign qP = p_q;

endmodule

// File: tb/tb_sub1b.sv
// Bench for sub1b: truth-table sweep, propagate, registered capture/reset,
// randomized stream against an arithmetic model, and a 4-bit cascade.
module tb_sub1b;

  logic clk, clk_en, rst;
  logic a, b, c;
  wire  os, oc, op, qs, qc, qp;

  int checks   = 0;
  int failures = 0;

  sub1b dut (
    .iA(a), .iB(b), .iC(c),
    .oS(os), .oC(oc), .oP(op),
    .iCLK(clk), .iRST(rst),
    .qS(qs), .qC(qc), .qP(qp)
  );

  // 4-bit ripple cascade built from four slices.
  logic [3:0] ca, cb;
  logic       cbin;
  wire  [4:0] bw;
  wire  [3:0] cd, cp, cqs, cqc, cqp;
  assign bw[0] = cbin;

  for (genvar g = 0; g < 4; g++) begin : g_casc
    sub1b u_slice (
      .iA(ca[g]), .iB(cb[g]), .iC(bw[g]),
      .oS(cd[g]), .oC(bw[g+1]), .oP(cp[g]),
      .iCLK(clk), .iRST(rst),
      .qS(cqs[g]), .qC(cqc[g]), .qP(cqp[g])
    );
  end

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: {borrow, diff, propagate} from plain integer subtraction.
  function automatic logic [2:0] ref_csp(input logic ra, input logic rb, input logic rc);
    int d;
    logic [31:0] dv;
    d  = int'(ra) - int'(rb) - int'(rc);
    dv = d;
    return {dv[1], dv[0], ra == rb};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] tt [8];
  logic       pt [4];
  logic [2:0] exp_q;
  logic [2:0] vec;
  logic [4:0] cexp;

  initial begin
    tt = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11};
    pt = '{1'b1, 1'b0, 1'b0, 1'b1};
    clk_en = 1'b0;
    rst = 1'b0;
    a = 0; b = 0; c = 0;
    ca = 0; cb = 0; cbin = 0;

    // Combinational sweep with the clock idle.
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {c, a, b} = vec;
      #10;
      chk($sformatf("comb_tt%0d", i), {6'b0, oc, os}, {6'b0, tt[i]});
      chk($sformatf("comb_ref%0d", i), {5'b0, oc, os, op}, {5'b0, ref_csp(a, b, c)});
    end

    // Propagate: with iC=1, oP follows a==b and oC equals iC whenever oP=1.
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #10;
      chk($sformatf("prop%0d", i), {7'b0, op}, {7'b0, pt[i]});
      if (pt[i]) chk($sformatf("prop_pass%0d", i), {7'b0, oc}, {7'b0, c});
    end

    // Reset over one edge; combinational outputs stay live.
    clk_en = 1'b1;
    a = 0; b = 1; c = 0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_q", {5'b0, qc, qs, qp}, 8'h00);
    chk("rst_comb", {5'b0, oc, os, op}, {5'b0, 3'b110});

    // Registered capture and hold across a mid-cycle input change.
    @(negedge clk);
    rst = 1'b0;
    {c, a, b} = 3'b100;
    @(posedge clk); #1;
    chk("cap_100", {5'b0, qc, qs, qp}, {5'b0, 3'b111});
    @(negedge clk);
    {c, a, b} = 3'b010;
    #1;
    chk("hold_q", {5'b0, qc, qs, qp}, {5'b0, 3'b111});
    @(posedge clk); #1;
    chk("cap_010", {5'b0, qc, qs, qp}, {5'b0, 3'b010});

    // Stream all vectors with reset asserted on cycle 4 only.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec = 3'(i);
      {c, a, b} = vec;
      rst = (i == 4);
      exp_q = (i == 4) ? 3'b000 : ref_csp(a, b, c);
      @(posedge clk); #1;
      chk($sformatf("stream%0d", i), {5'b0, qc, qs, qp}, {5'b0, exp_q});
    end

    // Randomized stream with occasional reset.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      vec = 3'($urandom_range(0, 7));
      {c, a, b} = vec;
      rst = ($urandom_range(0, 7) == 0);
      exp_q = rst ? 3'b000 : ref_csp(a, b, c);
      #1;
      chk($sformatf("rnd_comb%0d", i), {5'b0, oc, os, op}, {5'b0, ref_csp(a, b, c)});
      @(posedge clk); #1;
      chk($sformatf("rnd_q%0d", i), {5'b0, qc, qs, qp}, {5'b0, exp_q});
    end

    // Cascade: 0x3 - 0x5 - 0 = 0xE with borrow out.
    @(negedge clk);
    rst = 1'b0;
    ca = 4'h3; cb = 4'h5; cbin = 1'b0;
    #1;
    chk("casc_3m5", {3'b0, bw[4], cd}, {3'b0, 1'b1, 4'hE});

    for (int i = 0; i < 32; i++) begin
      int d;
      ca = 4'($urandom_range(0, 15));
      cb = 4'($urandom_range(0, 15));
      cbin = 1'($urandom_range(0, 1));
      d = int'(ca) - int'(cb) - int'(cbin);
      cexp = {d < 0, 4'(d & 15)};
      #1;
      chk($sformatf("casc_rnd%0d", i), {3'b0, bw[4], cd}, {3'b0, cexp});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub1b.md
Name: sub1b

Overview:
- 1-bit full subtractor slice for the 8085-compatible core ALU.
- Computes difference, borrow-out and borrow-propagate combinationally from minuend, subtrahend and borrow-in.
- Also provides a clocked, registered copy of those results for pipelined ALU use.
- Cascaded bit-wise to build multi-bit subtract/compare.

Parameters:
- None.

Ports:
- Declaration order is fixed: iA, iB, iC, oS, oC, oP, iCLK, iRST, qS, qC, qP.
- The first six positions must stay positional-compatible with existing instantiations.
- iCLK  input  1  clock; rising edge for the registered outputs.
- iRST  input  1  synchronous, active-high reset.
- iA    input  1  minuend bit (J).
- iB    input  1  subtrahend bit (K).
- iC    input  1  borrow-in (B).
- oS    output 1  difference bit (D), combinational.
- oC    output 1  borrow-out, combinational.
- oP    output 1  borrow-propagate, combinational.
- qS    output 1  registered oS.
- qC    output 1  registered oC.
- qP    output 1  registered oP.

Behaviour:
- Arithmetic: {oC,oS} equals the two LSBs of the two's-complement result of iA - iB - iC.
  - oS = iA XOR iB XOR iC.
  - oC = (~iA & iB) | (~(iA XOR iB) & iC).
  - oP = ~(iA XOR iB), i.e. a borrow-in passes through to borrow-out.
- Borrow-generate (~iA & iB) is internal only and not a port.
- Combinational outputs:
  - Zero-latency; no dependence on iCLK or iRST.
  - Valid within propagation delay of any input change.
  - They must work correctly even when iCLK is idle or never toggles.
  - Purely combinational path: no latches.
- Full truth table for {iC,iA,iB} -> {oC,oS}:
  - 000 -> 00
  - 001 -> 11
  - 010 -> 01
  - 011 -> 00
  - 100 -> 11
  - 101 -> 10
  - 110 -> 00
  - 111 -> 11
- oP for (iA,iB):
  - 00 -> 1
  - 01 -> 0
  - 10 -> 0
  - 11 -> 1
- Registered outputs:
  - On each iCLK rising edge with iRST=0: qS/qC/qP <= oS/oC/oP.
  - Latency is one cycle.
  - On a rising edge with iRST=1: qS=0, qC=0, qP=0, regardless of inputs.
  - Reset takes priority over capture; deassertion resumes capture on the next edge.
  - Before the first reset edge, q* are unspecified (X in simulation).
- X/Z on any input propagates to the combinational outputs; the bench treats that as failure.
- No other state. No enables.

Test Plan:
- Exhaustive combinational sweep: for loop 0..7, drive {iC,iA,iB}=loop and wait 10 time units, with no clock. Check {oC,oS} = LSBs of iA-iB-iC per the truth table, e.g. loop=1 -> {1,1}, loop=5 -> {1,0}, loop=6 -> {0,0}. Report OK/ERROR per vector.
- Propagate check: (iA,iB) = 00, 01, 10, 11 with iC=1 -> oP = 1, 0, 0, 1. oC follows iC exactly when oP=1.
- Reset: hold iA=0, iB=1, iC=0 (oS=1, oC=1, oP=0), assert iRST=1 over one rising edge -> qS=0, qC=0, qP=0. Combinational outputs remain 1, 1, 0.
- Registered capture: iRST=0, apply {iC,iA,iB}=100 -> after the next edge qC=1, qS=1, qP=1. Change to 010 mid-cycle -> q* unchanged until the following edge, then qC=0, qS=1, qP=0.
- Reset mid-stream: stream all 8 vectors one per cycle and assert iRST on cycle 4 -> q*=0 for that cycle only. The next edge captures the cycle-5 vector correctly.
- Cascade sanity: chain 4 instances (oC -> next iC), 0x3 - 0x5 with borrow-in 0 -> difference 0xE, final borrow 1.
